// File: rtl/seq_operand_read_stage_pkg.sv
// Shared encodings for the READ stage: NOP word and opcode values/field position.
package seq_operand_read_stage_pkg;

  localparam int          INSTR_W = 16;
  localparam int          OPC_MSB = 15;
  localparam int          OPC_LSB = 12;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  // Opcodes whose source usage differs from the generic two-source ALU form.
  localparam logic [3:0]  OP_NOP  = 4'h0;
  localparam logic [3:0]  OP_LOAD = 4'h1;
  localparam logic [3:0]  OP_LI   = 4'h3;

endpackage

// File: rtl/seq_operand_read_stage_extract.sv
// Decodes which source operand fields an opcode actually reads.
module comb_source_extractor
  import seq_operand_read_stage_pkg::*;
(
  input  logic [3:0] i_opcode,
  output logic       o_has_source1,
  output logic       o_has_source2
);

  // NOP and load-immediate read nothing; LOAD reads only its base register.
  always_comb begin
    o_has_source1 = 1'b1;
    o_has_source2 = 1'b1;
    if (i_opcode == OP_NOP || i_opcode == OP_LI) begin
      o_has_source1 = 1'b0;
      o_has_source2 = 1'b0;
    end else if (i_opcode == OP_LOAD) begin
      o_has_source2 = 1'b0;
    end
  end

endmodule

// File: rtl/seq_operand_read_stage.sv
// READ pipeline stage: holds one instruction, resolves its operands from the
// register file or forward paths, and registers the result toward EXECUTE.
//
// state   | meaning
// S_EMPTY | READ register holds nothing (o_instruction_read = NOP)
// S_FULL  | READ register holds an instruction waiting to issue
module seq_operand_read_stage
  import seq_operand_read_stage_pkg::*;
#(
  parameter int DATA_SIZE    = 32,
  parameter int ADDRESS_SIZE = 10,
  parameter int INSTR_SIZE   = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [INSTR_SIZE-1:0]   i_instruction,
  input  logic [ADDRESS_SIZE-1:0] i_pc,
  output logic [INSTR_SIZE-1:0]   o_instruction_read,
  input  logic [DATA_SIZE-1:0]    i_regfile_operand1,
  input  logic [DATA_SIZE-1:0]    i_regfile_operand2,
  input  logic                    i_forward_operand1_execute,
  input  logic                    i_forward_operand2_execute,
  input  logic                    i_forward_operand1_write,
  input  logic                    i_forward_operand2_write,
  input  logic [DATA_SIZE-1:0]    i_result_execute,
  input  logic [DATA_SIZE-1:0]    i_result_write,
  input  logic                    i_execute_is_load,
  input  logic                    i_flush,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [INSTR_SIZE-1:0]   o_instruction,
  output logic [ADDRESS_SIZE-1:0] o_pc,
  output logic [DATA_SIZE-1:0]    o_operand1,
  output logic [DATA_SIZE-1:0]    o_operand2
);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  localparam logic [INSTR_SIZE-1:0] W_NOP = INSTR_SIZE'(NOP_INSTR);

  state_t                  r_state, w_state_next;
  logic [INSTR_SIZE-1:0]   r_read_instr, w_read_instr_next;
  logic [ADDRESS_SIZE-1:0] r_read_pc, w_read_pc_next;

  logic                    r_exe_valid;
  logic [INSTR_SIZE-1:0]   r_exe_instr;
  logic [ADDRESS_SIZE-1:0] r_exe_pc;
  logic [DATA_SIZE-1:0]    r_exe_op1, r_exe_op2;

  logic w_has_src1, w_has_src2;
  logic w_fwd1_exec, w_fwd2_exec, w_fwd1_write, w_fwd2_write;
  logic w_slot_free, w_hazard, w_advance, w_capture;
  logic [DATA_SIZE-1:0] w_op1, w_op2;

  comb_source_extractor u_src (
    .i_opcode      (r_read_instr[OPC_MSB:OPC_LSB]),
    .o_has_source1 (w_has_src1),
    .o_has_source2 (w_has_src2)
  );

  // Forward flags only matter for fields the held instruction really reads.
  always_comb begin
    w_fwd1_exec  = w_has_src1 && i_forward_operand1_execute;
    w_fwd2_exec  = w_has_src2 && i_forward_operand2_execute;
    w_fwd1_write = w_has_src1 && i_forward_operand1_write;
    w_fwd2_write = w_has_src2 && i_forward_operand2_write;
  end

  // Operand source select: EXECUTE result beats WRITE result beats regfile.
  always_comb begin
    w_op1 = i_regfile_operand1;
    w_op2 = i_regfile_operand2;
    if (w_fwd1_exec)       w_op1 = i_result_execute;
    else if (w_fwd1_write) w_op1 = i_result_write;
    if (w_fwd2_exec)       w_op2 = i_result_execute;
    else if (w_fwd2_write) w_op2 = i_result_write;
  end

  // Handshake, load-use detection and READ register next state.
  always_comb begin
    w_slot_free       = !r_exe_valid || i_ready;
    w_hazard          = (r_state == S_FULL) && i_execute_is_load && (w_fwd1_exec || w_fwd2_exec);
    w_advance         = (r_state == S_FULL) && w_slot_free && !w_hazard && !i_flush;
    o_ready           = (r_state == S_EMPTY) || (w_slot_free && !w_hazard);
    w_capture         = i_valid && o_ready && !i_flush;
    w_state_next      = r_state;
    w_read_instr_next = r_read_instr;
    w_read_pc_next    = r_read_pc;
    if (i_flush) begin
      w_state_next      = S_EMPTY;
      w_read_instr_next = W_NOP;
      w_read_pc_next    = '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_capture) begin
            w_state_next      = S_FULL;
            w_read_instr_next = i_instruction;
            w_read_pc_next    = i_pc;
          end
        end
        S_FULL: begin
          if (w_advance) begin
            if (w_capture) begin
              w_read_instr_next = i_instruction;
              w_read_pc_next    = i_pc;
            end else begin
              w_state_next      = S_EMPTY;
              w_read_instr_next = W_NOP;
              w_read_pc_next    = '0;
            end
          end
        end
        default: w_state_next = S_EMPTY;
      endcase
    end
  end

  // READ register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_EMPTY;
      r_read_instr <= W_NOP;
      r_read_pc    <= '0;
    end else begin
      r_state      <= w_state_next;
      r_read_instr <= w_read_instr_next;
      r_read_pc    <= w_read_pc_next;
    end
  end

  // EXECUTE register: refills whenever the slot frees, with a bubble if nothing issues.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_exe_valid <= 1'b0;
      r_exe_instr <= W_NOP;
      r_exe_pc    <= '0;
      r_exe_op1   <= '0;
      r_exe_op2   <= '0;
    end else if (w_slot_free) begin
      if (w_advance) begin
        r_exe_valid <= 1'b1;
        r_exe_instr <= r_read_instr;
        r_exe_pc    <= r_read_pc;
        r_exe_op1   <= w_op1;
        r_exe_op2   <= w_op2;
      end else begin
        r_exe_valid <= 1'b0;
        r_exe_instr <= W_NOP;
        r_exe_pc    <= '0;
        r_exe_op1   <= '0;
        r_exe_op2   <= '0;
      end
    end
  end

  assign o_instruction_read = r_read_instr;
  assign o_valid            = r_exe_valid;
  assign o_instruction      = r_exe_instr;
  assign o_pc               = r_exe_pc;
  assign o_operand1         = r_exe_op1;
  assign o_operand2         = r_exe_op2;

endmodule

// File: tb/tb_seq_operand_read_stage.sv
// Bench for the READ stage: directed scenarios plus random traffic, checked
// against a transaction-level model (one-deep READ queue feeding an EXECUTE slot).
module tb_seq_operand_read_stage;

  localparam logic [15:0] NOP_I = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, o_ready;
  logic [15:0] i_instruction, o_instruction_read, o_instruction;
  logic [9:0]  i_pc, o_pc;
  logic [31:0] rf1, rf2, res_exe, res_wr, o_operand1, o_operand2;
  logic        f1e, f2e, f1w, f2w, is_load, flush, o_valid, i_ready;

  always #5 clk = ~clk;

  seq_operand_read_stage dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_instruction(i_instruction), .i_pc(i_pc), .o_instruction_read(o_instruction_read),
    .i_regfile_operand1(rf1), .i_regfile_operand2(rf2),
    .i_forward_operand1_execute(f1e), .i_forward_operand2_execute(f2e),
    .i_forward_operand1_write(f1w), .i_forward_operand2_write(f2w),
    .i_result_execute(res_exe), .i_result_write(res_wr),
    .i_execute_is_load(is_load), .i_flush(flush),
    .o_valid(o_valid), .i_ready(i_ready), .o_instruction(o_instruction),
    .o_pc(o_pc), .o_operand1(o_operand1), .o_operand2(o_operand2)
  );

  typedef struct { logic [15:0] instr; logic [9:0] pc; } rd_t;
  typedef struct { bit v; logic [15:0] instr; logic [9:0] pc; logic [31:0] op1, op2; } exe_t;

  rd_t  read_q[$];
  exe_t ex;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Source usage from the opcode: NOP/LI read nothing, LOAD reads src1 only.
  function automatic bit reads_src1(input logic [15:0] ins);
    return !(ins[15:12] inside {4'h0, 4'h3});
  endfunction
  function automatic bit reads_src2(input logic [15:0] ins);
    return !(ins[15:12] inside {4'h0, 4'h1, 4'h3});
  endfunction

  function automatic exe_t bubble();
    exe_t b;
    b.v = 0; b.instr = NOP_I; b.pc = '0; b.op1 = '0; b.op2 = '0;
    return b;
  endfunction

  task automatic model_reset();
    read_q.delete();
    ex = bubble();
  endtask

  // One clock: compare current outputs at negedge, advance model, cross posedge.
  task automatic step();
    bit    full, u1, u2, e1, e2, hz, room, rdy, adv, take;
    rd_t   head, nw;
    @(negedge clk);
    full = (read_q.size() != 0);
    if (full) head = read_q[0];
    else begin head.instr = NOP_I; head.pc = '0; end
    u1   = full && reads_src1(head.instr);
    u2   = full && reads_src2(head.instr);
    e1   = u1 && f1e;
    e2   = u2 && f2e;
    hz   = full && is_load && (e1 || e2);
    room = !ex.v || i_ready;
    rdy  = !full || (room && !hz);
    check_val("o_ready", o_ready, rdy);
    check_val("o_instruction_read", o_instruction_read, head.instr);
    check_val("o_valid", o_valid, ex.v);
    check_val("o_instruction", o_instruction, ex.instr);
    check_val("o_pc", o_pc, ex.pc);
    check_val("o_operand1", o_operand1, ex.op1);
    check_val("o_operand2", o_operand2, ex.op2);
    if (!rst_n) model_reset();
    else begin
      adv  = full && room && !hz && !flush;
      take = i_valid && rdy && !flush;
      if (room) begin
        if (adv) begin
          ex.v = 1; ex.instr = head.instr; ex.pc = head.pc;
          ex.op1 = e1 ? res_exe : (u1 && f1w) ? res_wr : rf1;
          ex.op2 = e2 ? res_exe : (u2 && f2w) ? res_wr : rf2;
        end else ex = bubble();
      end
      if (flush) read_q.delete();
      else begin
        if (adv) void'(read_q.pop_front());
        if (take) begin nw.instr = i_instruction; nw.pc = i_pc; read_q.push_back(nw); end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_valid = 0; i_instruction = '0; i_pc = '0; rf1 = '0; rf2 = '0;
    f1e = 0; f2e = 0; f1w = 0; f2w = 0; res_exe = '0; res_wr = '0;
    is_load = 0; flush = 0; i_ready = 1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0; i_valid = 1; i_instruction = 16'h4123; i_pc = 10'h3;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_val("rst o_valid", o_valid, 1'b0);
    check_val("rst o_ready", o_ready, 1'b1);
    check_val("rst o_operand1", o_operand1, 32'h0);
    check_val("rst o_operand2", o_operand2, 32'h0);
    check_val("rst o_instruction", o_instruction, NOP_I);
    check_val("rst o_instruction_read", o_instruction_read, NOP_I);
    rst_n = 1;

    // No forwarding: operands straight from the regfile.
    idle_inputs();
    rf1 = 32'h11; rf2 = 32'h22;
    i_valid = 1; i_instruction = 16'h4512; i_pc = 10'h10;
    step();
    i_valid = 0;
    step();
    check_val("nofwd valid", o_valid, 1'b1);
    check_val("nofwd op1", o_operand1, 32'h11);
    check_val("nofwd op2", o_operand2, 32'h22);

    // Forward priority: EXECUTE result wins over WRITE result.
    idle_inputs();
    i_valid = 1; i_instruction = 16'h5634; i_pc = 10'h11;
    step();
    i_valid = 0; f1e = 1; f1w = 1; res_exe = 32'hAAAA; res_wr = 32'hBBBB; rf1 = 32'h77;
    step();
    check_val("prio op1", o_operand1, 32'hAAAA);

    // Load-use: one bubble, then issue with the WRITE-path value.
    idle_inputs();
    i_valid = 1; i_instruction = 16'h6789; i_pc = 10'h12;
    step();
    i_valid = 1; i_instruction = 16'h7000; i_pc = 10'h13;
    is_load = 1; f2e = 1; res_exe = 32'hDEAD;
    #0;
    check_val("lu ready", o_ready, 1'b0);
    step();
    check_val("lu bubble", o_valid, 1'b0);
    check_val("lu bubble instr", o_instruction, NOP_I);
    is_load = 0; f2e = 0; f2w = 1; res_wr = 32'h1234; i_valid = 0;
    step();
    check_val("lu issue", o_valid, 1'b1);
    check_val("lu op2", o_operand2, 32'h1234);
    check_val("lu instr", o_instruction, 16'h6789);

    // Backpressure: stream with EXECUTE stalled for 3 cycles.
    idle_inputs();
    for (int k = 0; k < 8; k++) begin
      i_valid = 1; i_instruction = 16'h4000 | 16'(k); i_pc = 10'(k + 32);
      i_ready = !(k >= 2 && k < 5);
      step();
      if (o_ready || !i_valid) ;
    end

    // Flush with READ full and a same-cycle input.
    idle_inputs();
    i_valid = 1; i_instruction = 16'h8ABC; i_pc = 10'h40;
    step();
    i_instruction = 16'h9DEF; i_pc = 10'h41; flush = 1; i_ready = 0;
    step();
    check_val("flush read empty", o_instruction_read, NOP_I);
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      step();
      check_val("flush no issue", o_valid, 1'b0);
    end

    // Random traffic against the model, with occasional mid-run reset.
    for (int k = 0; k < 3000; k++) begin
      rst_n         = ($urandom_range(0, 199) != 0);
      i_valid       = ($urandom_range(0, 3) != 0);
      i_instruction = 16'($urandom);
      if ($urandom_range(0, 7) == 0) i_instruction[15:12] = 4'($urandom_range(0, 3));
      i_pc          = 10'($urandom);
      rf1 = $urandom; rf2 = $urandom; res_exe = $urandom; res_wr = $urandom;
      f1e = 1'($urandom); f2e = 1'($urandom); f1w = 1'($urandom); f2w = 1'($urandom);
      is_load = ($urandom_range(0, 3) == 0);
      flush   = ($urandom_range(0, 15) == 0);
      i_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
